// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU command at a time, issues it to an external
// multi-cycle ALU, waits for the result and holds it until the consumer takes it.
// Optional feature macro: ALU_SEQ_TIMEOUT_EN adds a WAIT-state timeout abort
// after TIMEOUT cycles without a qualified alu_rdy.
module alu_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic        alu_bgn,
  output logic [5:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic        alu_rdy,
  input  logic [15:0] alu_acc1,
  input  logic [15:0] alu_acc2,
  input  logic        alu_zero,
  input  logic        alu_negative,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_x,
  output logic [15:0] res_y,
  output logic [3:0]  res_flags,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_n;
  logic        first_wait, first_wait_n;
  logic        cmd_ready_n, alu_bgn_n, res_valid_n, busy_n;
  logic [5:0]  alu_opcode_n;
  logic [15:0] alu_a_n, alu_b_n, res_x_n, res_y_n;
  logic [3:0]  res_flags_n;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
  logic [CntW-1:0] cnt, cnt_n;
  logic            timeout_err_n;
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
  assign timeout_err    = 1'b0;
`endif

  // State and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      first_wait  <= 1'b0;
      cmd_ready   <= 1'b0;
      alu_bgn     <= 1'b0;
      alu_opcode  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      res_valid   <= 1'b0;
      res_x       <= '0;
      res_y       <= '0;
      res_flags   <= '0;
      busy        <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      cnt         <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      first_wait  <= first_wait_n;
      cmd_ready   <= cmd_ready_n;
      alu_bgn     <= alu_bgn_n;
      alu_opcode  <= alu_opcode_n;
      alu_a       <= alu_a_n;
      alu_b       <= alu_b_n;
      res_valid   <= res_valid_n;
      res_x       <= res_x_n;
      res_y       <= res_y_n;
      res_flags   <= res_flags_n;
      busy        <= busy_n;
`ifdef ALU_SEQ_TIMEOUT_EN
      cnt         <= cnt_n;
      timeout_err <= timeout_err_n;
`endif
    end
  end

  // Next-state and next-output logic; strobes are decoded from the next state.
  always_comb begin
    state_n       = state;
    first_wait_n  = 1'b0;
    alu_opcode_n  = alu_opcode;
    alu_a_n       = alu_a;
    alu_b_n       = alu_b;
    res_x_n       = res_x;
    res_y_n       = res_y;
    res_flags_n   = res_flags;
`ifdef ALU_SEQ_TIMEOUT_EN
    cnt_n         = cnt;
    timeout_err_n = timeout_err;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          alu_opcode_n = cmd_op;
          alu_a_n      = cmd_a;
          alu_b_n      = cmd_b;
          state_n      = ISSUE;
        end
      end
      ISSUE: begin
        first_wait_n = 1'b1;
        state_n      = WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
        cnt_n        = '0;
`endif
      end
      WAIT: begin
        // The first WAIT cycle may still see rdy left over from the previous op.
        if (!first_wait && alu_rdy) begin
          res_x_n       = alu_acc1;
          res_y_n       = alu_acc2;
          res_flags_n   = {alu_zero, alu_negative, alu_carry, alu_overflow};
          alu_opcode_n  = '0;
          state_n       = DONE;
`ifdef ALU_SEQ_TIMEOUT_EN
          timeout_err_n = 1'b0;
        end else if (cnt == TimeoutLast) begin
          res_x_n       = '0;
          res_y_n       = '0;
          res_flags_n   = '0;
          alu_opcode_n  = '0;
          timeout_err_n = 1'b1;
          state_n       = DONE;
        end else begin
          cnt_n         = cnt + CntW'(1);
`endif
        end
      end
      DONE: begin
        if (res_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    cmd_ready_n = (state_n == IDLE);
    alu_bgn_n   = (state_n == ISSUE);
    res_valid_n = (state_n == DONE);
    busy_n      = (state_n != IDLE);
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: randomized commands, a behavioural ALU
// model with configurable rdy delay / stale rdy, and a decoupled result monitor.
// Build with ALU_SEQ_TIMEOUT_EN defined to also exercise the timeout feature.
module tb_alu_sequencer;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [5:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic        alu_bgn;
  logic [5:0]  alu_opcode;
  logic [15:0] alu_a, alu_b;
  logic        alu_rdy;
  logic [15:0] alu_acc1, alu_acc2;
  logic        alu_zero, alu_negative, alu_carry, alu_overflow;
  logic        res_valid, res_ready;
  logic [15:0] res_x, res_y;
  logic [3:0]  res_flags;
  logic        busy, timeout_err;

  alu_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_bgn(alu_bgn), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_rdy(alu_rdy), .alu_acc1(alu_acc1), .alu_acc2(alu_acc2),
    .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_x(res_x), .res_y(res_y), .res_flags(res_flags),
    .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [3:0]  f;
    logic        terr;
    int          lat;
  } exp_t;

  typedef struct {
    int delay;
    bit stale;
    bit never;
  } cfg_t;

  exp_t sb[$];
  cfg_t alu_q[$];
  int   acc_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   bp_req = 0;
  bit   rnd_ready = 0;
  int   stall = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, cycle %0d required below 50000", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference ALU behaviour: {acc1, acc2, zero, negative, carry, overflow}.
  function automatic logic [35:0] alu_f(input logic [5:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] d;
    if (op == 6'd1) s = {1'b0, a} + {1'b0, b};
    else            s = {1'b0, a ^ b} + {11'b0, op};
    d = a - b;
    return {s[15:0], d, (s[15:0] == 16'h0), s[15], s[16],
            (a[15] == b[15]) && (s[15] != a[15])};
  endfunction

  function automatic bit times_out(input cfg_t c);
    return c.never || (c.delay > int'(TO));
  endfunction

  // WAIT cycle (1-based) in which the sequencer finishes waiting.
  function automatic int cap_cycle(input cfg_t c);
    if (times_out(c)) return int'(TO);
    return (c.delay < 2) ? 2 : c.delay;
  endfunction

  // ALU model: rdy from WAIT cycle 'delay' onward; optional stale rdy in WAIT cycle 1.
  initial begin
    int          k;
    bit          act;
    bit          prev_bgn;
    cfg_t        c;
    logic [35:0] newr, oldr;
    logic [5:0]  lop;
    logic [15:0] la, lb;
    k = 0; act = 0; prev_bgn = 0; newr = '0; oldr = '0; lop = '0; la = '0; lb = '0;
    c.delay = 1; c.stale = 0; c.never = 0;
    alu_rdy = 1'b0;
    {alu_acc1, alu_acc2, alu_zero, alu_negative, alu_carry, alu_overflow} = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 0;
        prev_bgn = 0;
      end else begin
        if (alu_bgn) begin
          chk("bgn_pulse", 96'(prev_bgn & alu_bgn), 96'(0));
          if (alu_q.size() == 0) begin
            chk("bgn_unexpected", 96'(alu_bgn), 96'(0));
          end else if (!prev_bgn) begin
            c = alu_q.pop_front();
            lop = alu_opcode; la = alu_a; lb = alu_b;
            oldr = newr;
            newr = alu_f(alu_opcode, alu_a, alu_b);
            act = 1;
            k = 0;
          end
        end else if (act && k >= 1 && k <= cap_cycle(c)) begin
          chk("operand_hold", 96'({alu_opcode, alu_a, alu_b}), 96'({lop, la, lb}));
        end
        prev_bgn = alu_bgn;
      end
      @(posedge clk);
      #1;
      if (rst || !act) begin
        alu_rdy = 1'b0;
        {alu_acc1, alu_acc2, alu_zero, alu_negative, alu_carry, alu_overflow} =
          36'({$urandom(), $urandom()});
      end else begin
        k++;
        if (!c.never && k >= c.delay) begin
          alu_rdy = 1'b1;
          {alu_acc1, alu_acc2, alu_zero, alu_negative, alu_carry, alu_overflow} = newr;
        end else if (c.stale && k == 1) begin
          alu_rdy = 1'b1;
          {alu_acc1, alu_acc2, alu_zero, alu_negative, alu_carry, alu_overflow} = oldr;
        end else begin
          alu_rdy = 1'b0;
          {alu_acc1, alu_acc2, alu_zero, alu_negative, alu_carry, alu_overflow} =
            36'({$urandom(), $urandom()});
        end
      end
    end
  end

  // Result consumer: optional 5-cycle stall on the next result, else random or always ready.
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_req && res_valid) begin
        stall = 5;
        bp_req = 0;
      end
      if (stall > 0) begin
        res_ready = 1'b0;
        stall--;
      end else begin
        res_ready = rnd_ready ? ($urandom_range(2) != 0) : 1'b1;
      end
    end
  end

  // Monitor: handshake expectations, result checks against the scoreboard.
  initial begin
    int          since;
    bit          inflight;
    bit          seen;
    logic [36:0] snap;
    exp_t        e;
    since = 0; inflight = 0; seen = 0; snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_outputs",
            96'({cmd_ready, alu_bgn, alu_opcode, alu_a, alu_b, res_valid, busy, timeout_err}),
            96'(0));
        chk("reset_results", 96'({res_x, res_y, res_flags}), 96'(0));
        since = 0; inflight = 0; seen = 0;
      end else begin
        chk("cmd_ready", 96'(cmd_ready), 96'(since >= 1 && !inflight));
        chk("busy", 96'(busy), 96'(inflight));
        since++;
        if (cmd_valid && cmd_ready) begin
          acc_q.push_back(cyc + 1);
          inflight = 1;
        end
        if (res_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 96'(res_valid), 96'(0));
          end else begin
            if (!seen) begin
              if (acc_q.size() != 0) chk("latency", 96'(cyc - acc_q[0]), 96'(sb[0].lat));
              chk("opcode_cleared", 96'(alu_opcode), 96'(0));
            end else begin
              chk("result_hold", 96'({res_x, res_y, res_flags, timeout_err}), 96'(snap));
            end
            snap = {res_x, res_y, res_flags, timeout_err};
            seen = 1;
            if (res_ready) begin
              e = sb.pop_front();
              if (acc_q.size() != 0) void'(acc_q.pop_front());
              chk("result", 96'({res_x, res_y, res_flags, timeout_err}),
                  96'({e.x, e.y, e.f, e.terr}));
              seen = 0;
              inflight = 0;
            end
          end
        end
      end
    end
  end

  // Offer one command; returns one cycle after it is accepted with cmd_valid still high.
  task automatic send(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                      input int delay, input bit stale, input bit never, input bit discard);
    cfg_t        c;
    exp_t        e;
    logic [35:0] r;
    bit          ok;
    c.delay = delay; c.stale = stale; c.never = never;
    r = alu_f(op, a, b);
    e.terr = times_out(c);
    e.x    = e.terr ? 16'h0 : r[35:20];
    e.y    = e.terr ? 16'h0 : r[19:4];
    e.f    = e.terr ? 4'h0  : r[3:0];
    e.lat  = 1 + cap_cycle(c);
    if (!discard) sb.push_back(e);
    alu_q.push_back(c);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    chk("accept_timeout", 96'(ok), 96'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("drain", 96'(sb.size()), 96'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    cfg_t c;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic ADD with minimum latency.
    send(6'd1, 16'h0003, 16'h0004, 1, 0, 0, 0);
    drain();

    // Stale rdy in the first WAIT cycle, real rdy later.
    send(6'd1, 16'h0010, 16'h0020, 1, 0, 0, 0);
    cmd_valid = 1'b0;
    send(6'd5, 16'(($urandom())), 16'($urandom()), 4, 1, 0, 0);
    drain();

    // Backpressure with cmd_valid held through the stalled result.
    bp_req = 1;
    send(6'd2, 16'h8000, 16'h8000, 2, 0, 0, 0);
    send(6'd1, 16'hFFFF, 16'h0001, 1, 1, 0, 0);
    drain();

    // Reset asserted in WAIT discards the operation.
    send(6'd3, 16'h1234, 16'h5678, 3, 0, 0, 1);
    cmd_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("async_reset",
           96'({cmd_ready, alu_bgn, alu_opcode, alu_a, alu_b, res_valid, res_x, busy,
                timeout_err}), 96'(0));
    @(posedge clk);
    alu_q.delete(); acc_q.delete(); sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    send(6'd1, 16'h7FFF, 16'h0001, 2, 0, 0, 0);
    drain();

`ifdef ALU_SEQ_TIMEOUT_EN
    // ALU never answers, rdy exactly on the timeout cycle, and rdy one cycle too late.
    send(6'd4, 16'hAAAA, 16'h5555, 8, 0, 1, 0);
    drain();
    send(6'd1, 16'h0100, 16'h0200, 8, 0, 0, 0);
    drain();
    send(6'd7, 16'h0F0F, 16'h00FF, 9, 0, 0, 0);
    drain();
`endif

    // Randomized traffic with random consumer backpressure.
    rnd_ready = 1;
    for (int n = 0; n < 40; n++) begin
`ifdef ALU_SEQ_TIMEOUT_EN
      c.delay = $urandom_range(11, 1);
      c.never = ($urandom_range(7) == 0);
`else
      c.delay = $urandom_range(6, 1);
      c.never = 0;
`endif
      c.stale = $urandom_range(1);
      send(6'($urandom()), 16'($urandom()), 16'($urandom()), c.delay, c.stale, c.never, 0);
      if ($urandom_range(1) == 1) begin
        cmd_valid = 1'b0;
        for (int j = 0; j < int'($urandom_range(3)); j++) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
